// File: rtl/buffer_lector.sv
// buffer_lector: pops pixels from a non-showahead FIFO into a sliding window handed off via valid/ready.
// Defining BUFFER_LECTOR_STATS_EN adds the win_count/stall_count statistics ports.
module buffer_lector #(
   parameter int DATA_WIDTH    = 8,
   parameter int BITS_FOR_DATA = 3,
   parameter int WINDOW_SIZE   = 3,
   parameter int STRIDE        = 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             enable,
   input  logic                             flush,
   input  logic [DATA_WIDTH-1:0]            fifo_data,
   input  logic                             fifo_empty,
   input  logic [BITS_FOR_DATA-1:0]         fifo_used,
   output logic                             fifo_read_req,
   output logic [DATA_WIDTH*WINDOW_SIZE-1:0] window_out,
   output logic                             window_valid,
   input  logic                             window_ready,
   output logic                             window_primed
`ifdef BUFFER_LECTOR_STATS_EN
   ,
   output logic [15:0]                      win_count,
   output logic [15:0]                      stall_count
`endif
);
   localparam int CW = $clog2(WINDOW_SIZE + 1);
   localparam int WW = DATA_WIDTH * WINDOW_SIZE;

   typedef enum logic {FETCH = 1'b0, PRESENT = 1'b1} state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   issued, captured, needed;
   logic            pending, accept, last_cap, starved;
   logic            unused_used;

   assign unused_used = ^fifo_used;
   assign accept      = window_valid & window_ready;
   // the final capture edge is also the FETCH->PRESENT edge, giving valid two cycles after the last request
   assign last_cap    = pending & (captured + CW'(1) == needed);
   assign starved     = (state == FETCH) & enable & fifo_empty & (issued < needed);

   always_ff @(posedge clk) begin
      if (!reset) state <= FETCH;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = flush ? FETCH
               : (state == FETCH) ? (last_cap ? PRESENT : FETCH)
               : (accept ? FETCH : PRESENT);
   end

   always_comb begin
      window_valid  = (state == PRESENT);
      fifo_read_req = reset & ~flush & (state == FETCH) & enable & ~fifo_empty & (issued < needed);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         window_out    <= '0;
         window_primed <= 1'b0;
         issued        <= '0;
         captured      <= '0;
         needed        <= CW'(WINDOW_SIZE);
         pending       <= 1'b0;
      end else if (flush) begin
         window_out    <= '0;
         window_primed <= 1'b0;
         issued        <= '0;
         captured      <= '0;
         needed        <= CW'(WINDOW_SIZE);
         pending       <= 1'b0;
      end else begin
         pending <= fifo_read_req;
         if (fifo_read_req) issued <= issued + CW'(1);
         if (pending) begin
            window_out <= {fifo_data, window_out[WW-1:DATA_WIDTH]};
            captured   <= captured + CW'(1);
         end
         if (accept) begin
            window_primed <= 1'b1;
            issued        <= '0;
            captured      <= '0;
            needed        <= CW'(STRIDE);
         end
      end
   end

`ifdef BUFFER_LECTOR_STATS_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         win_count   <= '0;
         stall_count <= '0;
      end else begin
         if (accept && win_count != 16'hFFFF) win_count <= win_count + 16'd1;
         if (starved && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
      end
   end
`endif
endmodule

// File: doc/buffer_lector.md
Name: buffer_lector

Overview:
- Read-side controller for the row FIFO buffer unit. Pops pixels from the FIFO using its read request, empty flag and used-word count.
- Assembles the pixels into a sliding window of WINDOW_SIZE pixels and hands each window downstream to the filter datapath with a valid/ready handshake.
- Accounts for the FIFO's 1-cycle read latency (non-showahead). Never issues a read on an empty FIFO.

Parameters:
- DATA_WIDTH, 8, pixel width; must match the FIFO data width.
- BITS_FOR_DATA, 3, width of the FIFO used-word count.
- WINDOW_SIZE, 3, pixels per window; range 2..8.
- STRIDE, 1, new pixels shifted in per window after the first; range 1..WINDOW_SIZE.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  allows new FIFO reads; when low, no reads are issued.
- flush  in  1  one-cycle end-of-row pulse; discards the partial/held window.
- fifo_data  in  DATA_WIDTH  FIFO read data (q).
- fifo_empty  in  1  FIFO empty flag.
- fifo_used  in  BITS_FOR_DATA  FIFO used-word count; observational, not used for gating.
- fifo_read_req  out  1  FIFO read request; combinational.
- window_out  out  DATA_WIDTH*WINDOW_SIZE  window; slot 0 (LSBs) is the oldest pixel.
- window_valid  out  1  window_out is valid.
- window_ready  in  1  downstream accepts the window.
- window_primed  out  1  at least one full window has been assembled since reset/flush.

Behaviour:
- Reset values (reset low at a clk edge): state=FETCH, window_out=0, window_valid=0, window_primed=0, issue and capture counters=0, pending=0.
  - fifo_read_req=0 while reset is low.
  - A reset mid-operation discards everything, including any read in flight.
- needed = window_primed ? STRIDE : WINDOW_SIZE, latched on entry to FETCH.
- Read issue: fifo_read_req = (state==FETCH) & enable & ~fifo_empty & (issued < needed).
- Read latency: pending <= fifo_read_req each cycle. When pending=1, fifo_data is captured at that clock edge.
- Capture: window shifts down one slot; fifo_data enters slot WINDOW_SIZE-1; captured increments.
- State FETCH:
  - Reads are issued up to one per cycle.
  - When captured==needed, go to PRESENT on the following edge.
  - window_valid goes high 2 cycles after the last read request.
  - Back-to-back reads are allowed. An empty FIFO stalls issue with no penalty beyond the stall cycles.
- State PRESENT:
  - window_valid=1; window_out is held stable while window_ready=0.
  - On valid&ready: window_primed<=1, counters cleared, needed recomputed, return to FETCH.
  - No reads are issued in PRESENT; there is no read-ahead.
- Sliding behaviour: after the first window, each new window keeps WINDOW_SIZE-STRIDE old pixels and shifts in STRIDE new ones.
  - With STRIDE=WINDOW_SIZE, windows are disjoint.
- flush (highest priority after reset):
  - Next state FETCH; window_valid=0; window_primed=0; counters=0; window_out=0.
  - A read issued in the flush cycle, or still pending, is consumed and its data discarded.
  - fifo_read_req is forced 0 in the flush cycle.
- flush coincident with valid&ready: the handshake completes (the window counts as delivered), then the flush takes effect.
- enable low mid-FETCH: issue pauses; in-flight capture still completes; partial progress is retained.
- Counter widths: issued/captured are clog2(WINDOW_SIZE+1) bits and never exceed needed.

Optional Feature:
- Macro: BUFFER_LECTOR_STATS_EN.
- Defined: adds output ports win_count[15:0] and stall_count[15:0], both reset to 0 and saturating at 0xFFFF.
  - win_count increments on each valid&ready.
  - stall_count increments each cycle in FETCH with enable=1, fifo_empty=1 and issued<needed.
  - flush does not clear either counter.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset, enable=1, window_ready=1, FIFO holds 0x11,0x22,0x33 (WINDOW_SIZE=3, STRIDE=1) -> fifo_read_req high 3 consecutive cycles; window_valid 2 cycles after the last request; window_out=0x332211; window_primed=1 after transfer.
- Then push 0x44 -> exactly 1 read; next window_out=0x443322.
- window_ready=0 for 5 cycles while a window is valid -> window_out stable; no fifo_read_req; on ready=1 the transfer occurs once.
- FIFO empty after 2 of 3 pixels (0xA1,0xA2), then push 0xA3 six cycles later -> no read while empty; window_out=0xA3A2A1; with the macro defined, stall_count=6.
- flush asserted the cycle after a read request of 0x55 -> 0x55 discarded, window_primed=0; the next window requires 3 fresh reads.
- reset low during PRESENT with window_valid=1 -> next cycle window_valid=0, window_out=0, fifo_read_req=0.
